// File: rtl/switch_ctrl_pkg.sv
// Shared constants for the switch input controller: register map, default
// debounce timing and the debounce counter width helper.
package switch_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_EDGE   = 2'd2;
    localparam logic [1:0] ADDR_TSTAMP = 2'd3;

    localparam int DEF_TICK_DIV  = 50000;
    localparam int DEF_DEB_TICKS = 10;

    // One spare bit so the counter can never wrap before the compare fires.
    function automatic int deb_cnt_width(input int deb_ticks);
        return $clog2(deb_ticks) + 1;
    endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// Single-bit debouncer: flips its stable output only after DEB_TICKS
// consecutive sample ticks that disagree with the current stable value.
module switch_debounce_bit
    import switch_ctrl_pkg::*;
#(
    parameter int DEB_TICKS = DEF_DEB_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sync_in,
    output logic stable_out
);

    localparam int CW = deb_cnt_width(DEB_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_TICKS - 1);

    logic [CW-1:0] cnt_reg, cnt_next;
    logic          stable_reg, stable_next;

    always_comb begin
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        if (tick) begin
            if (sync_in != stable_reg) begin
                // >= rather than == keeps the counter bounded even if it is ever corrupted
                if (cnt_reg >= CNT_LAST) begin
                    stable_next = ~stable_reg;
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end else begin
                cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            stable_reg <= stable_next;
        end
    end

    assign stable_out = stable_reg;

endmodule

// File: rtl/switch_input_ctrl.sv
// Avalon-MM switch input controller: synchronize, debounce, capture rising
// edges and interrupt. Optional capture timestamp: SWITCH_CTRL_TIMESTAMP_EN.
module switch_input_ctrl
    import switch_ctrl_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int DEB_TICKS = DEF_DEB_TICKS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    input  logic [1:0]       address,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int PW = $clog2(TICK_DIV);

    logic [WIDTH-1:0] sync1_reg, sync2_reg;
    logic [PW-1:0]    presc_reg;
    logic             tick;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_prev_reg;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] edge_reg, edge_next;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      readdata_reg, readdata_next;
    logic [31:0]      tstamp;
    logic             unused_wdata;

    assign unused_wdata = &{1'b0, writedata};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            presc_reg <= '0;
        end else begin
            sync1_reg <= in_port;
            sync2_reg <= sync1_reg;
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
        end
    end

    assign tick = (presc_reg == PW'(TICK_DIV - 1));

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_deb
            switch_debounce_bit #(
                .DEB_TICKS (DEB_TICKS)
            ) u_deb (
                .clk        (clk),
                .reset      (reset),
                .tick       (tick),
                .sync_in    (sync2_reg[gi]),
                .stable_out (stable[gi])
            );
        end
    endgenerate

    // A fresh rising edge is OR-ed in after the clear so it survives a colliding W1C.
    always_comb begin
        w1c = '0;
        if (!write_n && address == ADDR_EDGE) begin
            w1c = writedata[WIDTH-1:0];
        end
        edge_next = (edge_reg & ~w1c) | (stable & ~stable_prev_reg);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_prev_reg <= '0;
            edge_reg        <= '0;
            mask_reg        <= '0;
        end else begin
            stable_prev_reg <= stable;
            edge_reg        <= edge_next;
            if (!write_n && address == ADDR_MASK) begin
                mask_reg <= writedata[WIDTH-1:0];
            end
        end
    end

`ifdef SWITCH_CTRL_TIMESTAMP_EN
    logic [31:0] cyc_reg;
    logic [31:0] tstamp_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_reg    <= '0;
            tstamp_reg <= '0;
        end else begin
            cyc_reg <= cyc_reg + 32'd1;
            if (edge_reg == '0 && edge_next != '0) begin
                tstamp_reg <= cyc_reg;
            end
        end
    end

    assign tstamp = tstamp_reg;
`else
    assign tstamp = '0;
`endif

    always_comb begin
        readdata_next = '0;
        case (address)
            ADDR_DATA:   readdata_next[WIDTH-1:0] = stable;
            ADDR_MASK:   readdata_next[WIDTH-1:0] = mask_reg;
            ADDR_EDGE:   readdata_next[WIDTH-1:0] = edge_reg;
            ADDR_TSTAMP: readdata_next            = tstamp;
            default:     readdata_next            = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_reg <= '0;
        end else begin
            readdata_reg <= readdata_next;
        end
    end

    assign readdata = readdata_reg;
    assign irq      = |(edge_reg & mask_reg);

endmodule
